// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: memory request/response plus the instruction
// handshake toward the core.
//   master : fetch unit side (drives requests, consumes responses,
//            presents instructions)
//   slave  : environment side (memory and core)
interface instr_fetch_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word addresses to memory,
// buffers in-order responses in a prefetch queue and hands them to the
// core over a valid/ready handshake. Supports redirect (flush) and
// stops after requesting last_pc.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   last_pc          final word address to request
//   flush, flush_pc  one-cycle redirect strobe and new address
//   done             last_pc fetched, queue and memory pipeline drained
//   bus              instr_fetch_if.master (memory req/rsp, instr out)
// Optional: define INSTR_FETCH_TRACE_EN for a $strobe trace of pops
// and flushes.
module instr_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   last_pc,
    input  logic          flush,
    input  logic [31:0]   flush_pc,
    output logic          done,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic          stopped;
    logic [CW-1:0] live;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;

    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] q_wr;
    logic [AW-1:0] q_rd;

    // Addresses of kept outstanding requests, in issue order.
    logic [31:0]   tag_pc [DEPTH];
    logic [AW-1:0] t_wr;
    logic [AW-1:0] t_rd;

    logic [CW:0]   credit;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          pop;

    // Buffered plus in-flight kept words may never exceed the queue.
    assign credit   = {1'b0, live} + {1'b0, count};

    assign bus.mem_req_valid = rst_n && !flush && !stopped &&
                               (credit < (CW+1)'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;

    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign rsp_drop = bus.mem_rsp_valid && (drop != '0);
    assign rsp_keep = bus.mem_rsp_valid && (drop == '0);
    assign pop      = bus.instr_valid && bus.instr_ready;

    assign bus.instr_valid = (count != '0);
    assign bus.instr_data  = q_data[q_rd];
    assign bus.instr_pc    = q_pc[q_rd];

    assign done = stopped && (count == '0) &&
                  (live == '0) && (drop == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            stopped  <= 1'b0;
            live     <= '0;
            drop     <= '0;
            count    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            t_wr     <= '0;
            t_rd     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_data[i] <= '0;
                tag_pc[i] <= '0;
            end
        end else if (flush) begin
            // Everything still in flight becomes garbage, including
            // the response arriving right now.
            drop     <= drop + live - CW'(bus.mem_rsp_valid);
            live     <= '0;
            count    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            t_wr     <= '0;
            t_rd     <= '0;
            fetch_pc <= flush_pc;
            stopped  <= 1'b0;
        end else begin
            if (req_fire) begin
                tag_pc[t_wr] <= fetch_pc;
                t_wr         <= t_wr + AW'(1);
                if (fetch_pc == last_pc) begin
                    stopped <= 1'b1;
                end else begin
                    fetch_pc <= fetch_pc + 32'd1;
                end
            end
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
            if (rsp_keep) begin
                q_pc[q_wr]   <= tag_pc[t_rd];
                q_data[q_wr] <= bus.mem_rsp_data;
                q_wr         <= q_wr + AW'(1);
                t_rd         <= t_rd + AW'(1);
            end
            if (pop) begin
                q_rd <= q_rd + AW'(1);
            end
            live  <= live + CW'(req_fire) - CW'(rsp_keep);
            count <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

`ifdef INSTR_FETCH_TRACE_EN
    // Head is captured before the edge so the strobe shows the
    // popped word rather than the next one.
    logic [31:0] trace_pc;
    logic [31:0] trace_data;
    always @(posedge clk) begin
        if (rst_n && flush) begin
            $strobe("FETCH: flush -> %h", flush_pc);
        end else if (rst_n && pop) begin
            trace_pc   = bus.instr_pc;
            trace_data = bus.instr_data;
            $strobe("FETCH: [%h] %h", trace_pc, trace_data);
        end
    end
`else
`endif

endmodule
